// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
//
// Each requester has a valid/ready request port and a one-entry response
// slot. At most one request is granted per cycle, using round-robin between
// the ports that are eligible. The granted operands drive the ALU
// combinationally. The ALU result and flags are captured into that port's
// slot at the next rising edge, so latency is 1 cycle.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   reqN_valid/ready           request handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_ctrl  operands and ALU control
//   rspN_valid/ready           response handshake
//   rspN_result, rspN_flags    registered result and {N, Z, C, V}
//   rspN_err                   the accepted op had an illegal ctrl
//   alu_a, alu_b, alu_ctrl     drive to the shared ALU
//   alu_result, alu_flags      combinational return from the ALU

// One response slot: loads on grant, and clears on drain when not reloaded.
module alu_arbiter_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             err,
    input  logic             drain,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        if (load) begin
            valid_d  = 1'b1;
            // For an illegal op the ALU output is meaningless, so zero it.
            result_d = err ? '0 : alu_result;
            flags_d  = err ? 4'b0000 : alu_flags;
            err_d    = err;
        end else if (valid_q && drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
endmodule

module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic [3:0]        rsp0_flags,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic [3:0]        rsp1_flags,
    output logic              rsp1_err,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [3:0]        alu_flags
);
    localparam logic [CTRL_W-1:0] CTRL_MAX_LEGAL = CTRL_W'(4);

    logic [1:0]       req_valid, rsp_ready, rsp_valid, elig, grant, rsp_err;
    logic [WIDTH-1:0] rsp_result [2];
    logic [3:0]       rsp_flags  [2];
    logic             illegal;
    logic             last_grant_q, last_grant_d;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Grant depends only on request valids, slot state and last_grant. It
    // never looks at the ALU return, so ready has no path from alu_*.
    always_comb begin
        for (int n = 0; n < 2; n++)
            elig[n] = req_valid[n] & (~rsp_valid[n] | rsp_ready[n]);
        grant = 2'b00;
        if (!reset) begin
            if (elig == 2'b11)
                grant = last_grant_q ? 2'b01 : 2'b10;
            else
                grant = elig;
        end

        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (grant[0]) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (grant[1]) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
        illegal = alu_ctrl > CTRL_MAX_LEGAL;

        last_grant_d = last_grant_q;
        if (grant[0])      last_grant_d = 1'b0;
        else if (grant[1]) last_grant_d = 1'b1;
    end

    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        alu_arbiter_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .load       (grant[gi]),
            .err        (illegal),
            .drain      (rsp_ready[gi]),
            .alu_result (alu_result),
            .alu_flags  (alu_flags),
            .rsp_valid  (rsp_valid[gi]),
            .rsp_result (rsp_result[gi]),
            .rsp_flags  (rsp_flags[gi]),
            .rsp_err    (rsp_err[gi])
        );
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_result[0];
    assign rsp1_result = rsp_result[1];
    assign rsp0_flags  = rsp_flags[0];
    assign rsp1_flags  = rsp_flags[1];
    assign rsp0_err    = rsp_err[0];
    assign rsp1_err    = rsp_err[1];
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit datapath ALU between two requesters, such as the execute-stage controller and a multicycle helper, using valid/ready handshakes and round-robin arbitration. The arbiter drives the external ALU operands and control combinationally from the granted request. It registers the ALU result and flags into a one-entry response buffer per requester. Throughput is one ALU operation per clock across both ports, with 1-cycle latency.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- CTRL_W, 3, ALU control width.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  (N = 0, 1) request N presents an operation.
- reqN_ready  out  1  request N accepted this cycle (valid & ready = accept).
- reqN_a, reqN_b  in  WIDTH  operands.
- reqN_ctrl  in  CTRL_W  ALU control: 00x add/sub, 010 AND, 011 OR, 100 XOR.
- rspN_valid  out  1  response N holds a result.
- rspN_ready  in  1  requester N consumes response.
- rspN_result  out  WIDTH  registered ALU result.
- rspN_flags  out  4  registered {N, Z, C, V}.
- rspN_err  out  1  accepted op had an illegal ctrl (101, 110, 111).
- alu_a, alu_b  out  WIDTH  to the shared ALU.
- alu_ctrl  out  CTRL_W  to the shared ALU.
- alu_result  in  WIDTH  from the ALU, combinational.
- alu_flags  in  4  from the ALU, combinational.

## Operation
- **State:**
  - last_grant (1 bit).
  - Per port: rsp_valid, rsp_result, rsp_flags, rsp_err.
- **Eligibility:** port N is eligible when reqN_valid is high and its slot is free. The slot is free when rspN_valid = 0, or when rspN_valid & rspN_ready are both high this cycle (drain and refill in the same cycle is allowed).
- **Grant:**
  - Only one eligible port: that port wins.
  - Both eligible: the port ≠ last_grant wins.
  - None eligible: no grant.
- reqN_ready = grant_N. Both ready signals are never high together.
- **On grant:**
  - alu_a/alu_b/alu_ctrl = the granted port's fields.
  - At the clock edge: the response slot loads alu_result/alu_flags, rsp_valid ← 1, and last_grant ← granted port.
- **Idle:** alu_a = 0, alu_b = 0, alu_ctrl = 3'b000.
- **Illegal ctrl** (101, 110, 111):
  - The op is still granted and consumes the cycle.
  - The ALU output is ignored: rsp_result ← 0, rsp_flags ← 4'b0000, rsp_err ← 1.
  - Legal ops load rsp_err ← 0.
- **Drain:** when rspN_valid & rspN_ready and there is no new grant to N, rspN_valid ← 0. Data registers hold their last value.
- **Requester rule:** reqN_* must stay stable while valid & ~ready. Withdrawing a request before it is accepted is tolerated and leaves no side effect.
- Responses are returned strictly in per-port order, which is trivially true with a 1-deep slot.

## Timing
- **Reset (asynchronous, immediate):**
  - rspN_valid = 0, rspN_result = 0, rspN_flags = 0, rspN_err = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - Any in-flight response is discarded.
- reqN_ready is a combinational function of reqN_valid, rspN_valid, rspN_ready and last_grant. There is no combinational path from the alu_* inputs to any ready.
- **Latency:** accept at edge k, rspN_valid high from edge k+1.
- **Back-pressure:** with rspN_ready held low, rspN_valid and its data hold. Port N is then ineligible, and the other port gets every cycle.
- **Sustained traffic:** with both ports continuously valid and responses always drained, grants alternate 0,1,0,1…; each port gets 50% of cycles.
- **Reset released mid-stream:** the first cycle after deassertion behaves as post-reset, with no stale responses.

## Test plan
- Port 0 sends a=5, b=3, ctrl=000 → req0_ready=1 that cycle; next cycle rsp0_valid=1, result=8, flags=0000.
- Port 1 sends a=3, b=3, ctrl=001 → result=0, flags=0110. Separately, a=0x7FFFFFFF, b=1, ctrl=000 → result=0x80000000, flags=1001.
- Both ports valid in the first cycle after reset → port 0 granted first, port 1 the following cycle. Held for 8 cycles, grants alternate 0/1 exactly.
- Hold rsp0_ready=0 after one port-0 op, keep req0 and req1 valid → rsp0 data stable, req0_ready=0, port 1 granted every cycle. Raise rsp0_ready → the same cycle drains rsp0 and grants port 0 if last_grant=1.
- Port 1 sends ctrl=111, a=9, b=4 → rsp1_err=1, result=0, flags=0000. A following legal op clears err.
- Assert reset while rsp0_valid=1 and req1 is pending → all rspN_valid drop immediately, no ALU drive, and port 0 wins the first post-reset tie.
